// File: rtl/ahb_lite_mem_test_reporter_pkg.sv
// =============================================================================
// Module   : ahb_lite_mem_test_reporter_pkg
// Brief    : ASCII constants, line layout, FSM encoding and formatting helpers
//            for the memory-test status reporter.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package ahb_lite_mem_test_reporter_pkg;

    localparam logic [7:0] c_ascii_f  = 8'h46;
    localparam logic [7:0] c_ascii_p  = 8'h50;
    localparam logic [7:0] c_ascii_c  = 8'h43;
    localparam logic [7:0] c_ascii_w  = 8'h57;
    localparam logic [7:0] c_ascii_i  = 8'h49;
    localparam logic [7:0] c_ascii_sp = 8'h20;
    localparam logic [7:0] c_ascii_cr = 8'h0D;
    localparam logic [7:0] c_ascii_lf = 8'h0A;

    // Status codes are the ASCII letters themselves, so the code byte goes straight on the wire.
    localparam logic [7:0] c_status_failed  = c_ascii_f;
    localparam logic [7:0] c_status_success = c_ascii_p;
    localparam logic [7:0] c_status_check   = c_ascii_c;
    localparam logic [7:0] c_status_write   = c_ascii_w;
    localparam logic [7:0] c_status_idle    = c_ascii_i;

    // code, space, 2 hex, space, 8 hex, CR, LF -> 15 bytes on the wire.
    localparam int         c_line_len = 15;
    localparam logic [3:0] c_last_idx = 4'(c_line_len - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_TX = 3'd3,
        ST_DONE    = 3'd4
    } line_state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] line_byte(input logic [3:0]  idx,
                                             input logic [7:0]  code,
                                             input logic [7:0]  chk,
                                             input logic [31:0] err);
        logic [7:0] b;
        case (idx)
            4'd0:    b = code;
            4'd1:    b = c_ascii_sp;
            4'd2:    b = nibble_to_ascii(chk[7:4]);
            4'd3:    b = nibble_to_ascii(chk[3:0]);
            4'd4:    b = c_ascii_sp;
            4'd5:    b = nibble_to_ascii(err[31:28]);
            4'd6:    b = nibble_to_ascii(err[27:24]);
            4'd7:    b = nibble_to_ascii(err[23:20]);
            4'd8:    b = nibble_to_ascii(err[19:16]);
            4'd9:    b = nibble_to_ascii(err[15:12]);
            4'd10:   b = nibble_to_ascii(err[11:8]);
            4'd11:   b = nibble_to_ascii(err[7:4]);
            4'd12:   b = nibble_to_ascii(err[3:0]);
            4'd13:   b = c_ascii_cr;
            default: b = c_ascii_lf;
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_lite_mem_test_reporter_if.sv
// =============================================================================
// Module   : ahb_lite_mem_test_reporter_if
// Brief    : Status bundle from the memory test master plus the reporter's
//            serial line and busy flag.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface ahb_lite_mem_test_reporter_if;
    logic [31:0] ERRCOUNT;
    logic [7:0]  CHKCOUNT;
    logic        S_WRITE;
    logic        S_CHECK;
    logic        S_SUCCESS;
    logic        S_FAILED;
    logic        UART_TX;
    logic        BUSY;

    modport master (
        output ERRCOUNT, CHKCOUNT, S_WRITE, S_CHECK, S_SUCCESS, S_FAILED,
        input  UART_TX, BUSY
    );

    modport slave (
        input  ERRCOUNT, CHKCOUNT, S_WRITE, S_CHECK, S_SUCCESS, S_FAILED,
        output UART_TX, BUSY
    );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_mem_test_reporter_uart_tx_byte.sv
// =============================================================================
// Module   : uart_tx_byte
// Brief    : 8N1 UART transmitter, LSB first; one-cycle done at end of stop bit.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic       HCLK,
    input  wire logic       HRESET,
    input  wire logic       start,
    input  wire logic [7:0] data,
    output logic            tx,
    output logic            done
);

    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         c_stop_bit = 4'd9;

    logic               r_busy;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_bit;
    logic [8:0]         r_shift;
    logic               r_tx;
    logic               r_done;

    // r_bit counts frame slots: 0 = start, 1..8 = data, 9 = stop.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= 4'd0;
            r_shift <= '1;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (start) begin
                    r_busy  <= 1'b1;
                    r_tx    <= 1'b0;
                    r_shift <= {1'b1, data};
                    r_cnt   <= '0;
                    r_bit   <= 4'd0;
                end
            end else if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                if (r_bit == c_stop_bit) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_tx   <= 1'b1;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign tx   = r_tx;
    assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/ahb_lite_mem_test_reporter.sv
// =============================================================================
// Module   : ahb_lite_mem_test_reporter
// Brief    : Watches memory-test status and emits a one-line ASCII report over
//            UART whenever status or check count changes (or periodically).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module ahb_lite_mem_test_reporter
    import ahb_lite_mem_test_reporter_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 434,
    parameter int REPORT_PERIOD = 0
) (
    input  wire logic                    HCLK,
    input  wire logic                    HRESET,
    ahb_lite_mem_test_reporter_if.slave  bus
);

    logic [7:0]  w_code;
    logic        w_period_hit;
    logic        w_trig;
    logic [7:0]  w_byte;
    logic [7:0]  w_next_byte;
    logic        w_tx;
    logic        w_done;

    line_state_t r_state;
    logic [7:0]  r_prev_code;
    logic [7:0]  r_prev_chk;
    logic        r_trig;
    logic        r_pending;
    logic [3:0]  r_idx;
    logic [7:0]  r_snap_code;
    logic [7:0]  r_snap_chk;
    logic [31:0] r_snap_err;
    logic [7:0]  r_byte;
    logic        r_start;
    logic        r_busy;

    always_comb begin
        w_code = c_status_idle;
        if (bus.S_FAILED)       w_code = c_status_failed;
        else if (bus.S_SUCCESS) w_code = c_status_success;
        else if (bus.S_CHECK)   w_code = c_status_check;
        else if (bus.S_WRITE)   w_code = c_status_write;
    end

    generate
        if (REPORT_PERIOD != 0) begin : g_period_on
            localparam logic [31:0] c_period_last = 32'(REPORT_PERIOD - 1);
            logic [31:0] r_period;

            // Free-running: keeps counting while a line is in flight.
            always_ff @(posedge HCLK) begin
                if (HRESET)                       r_period <= '0;
                else if (r_period == c_period_last) r_period <= '0;
                else                              r_period <= r_period + 32'd1;
            end

            assign w_period_hit = (r_period == c_period_last);
        end else begin : g_period_off
            assign w_period_hit = 1'b0;
        end
    endgenerate

    assign w_trig = (w_code != r_prev_code) || (bus.CHKCOUNT != r_prev_chk) || w_period_hit;

    assign w_byte      = line_byte(r_idx, r_snap_code, r_snap_chk, r_snap_err);
    assign w_next_byte = line_byte(r_idx + 4'd1, r_snap_code, r_snap_chk, r_snap_err);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_prev_code <= c_status_idle;
            r_prev_chk  <= 8'h00;
            r_trig      <= 1'b0;
            r_pending   <= 1'b0;
            r_idx       <= 4'd0;
            r_snap_code <= c_status_idle;
            r_snap_chk  <= 8'h00;
            r_snap_err  <= 32'h0;
            r_byte      <= 8'h00;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_prev_code <= w_code;
            r_prev_chk  <= bus.CHKCOUNT;
            r_trig      <= w_trig;
            r_start     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // A trigger landing together with pending folds into this one snapshot.
                    if (r_trig || r_pending) begin
                        r_snap_code <= w_code;
                        r_snap_chk  <= bus.CHKCOUNT;
                        r_snap_err  <= bus.ERRCOUNT;
                        r_pending   <= 1'b0;
                        r_idx       <= 4'd0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_byte  <= w_byte;
                    r_start <= 1'b1;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (w_done) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_byte  <= w_next_byte;
                            r_start <= 1'b1;
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            if ((r_state != ST_IDLE) && r_trig) begin
                r_pending <= 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .start  (r_start),
        .data   (r_byte),
        .tx     (w_tx),
        .done   (w_done)
    );

    assign bus.UART_TX = w_tx;
    assign bus.BUSY    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_mem_test_reporter.sv
// =============================================================================
// Module   : tb_ahb_lite_mem_test_reporter
// Brief    : Scoreboard bench: expected line bytes are queued by stimulus and
//            popped by a UART receive monitor decoding UART_TX.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_ahb_lite_mem_test_reporter;

    localparam int CPB = 4;

    logic HCLK = 1'b0;
    logic HRESET;

    always #5 HCLK = ~HCLK;

    ahb_lite_mem_test_reporter_if bus ();

    ahb_lite_mem_test_reporter #(
        .CLKS_PER_BIT  (CPB),
        .REPORT_PERIOD (0)
    ) u_dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    int         n_vec    = 0;
    int         n_miss   = 0;
    int         rx_count = 0;
    bit         discard  = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_b;
    logic       rx_stop;
    logic [7:0] rx_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || bus.BUSY) && c < budget) begin
            @(negedge HCLK);
            c++;
        end
        check(name, (c < budget), 1'b1);
    endtask

    // UART receive monitor: samples mid-bit, compares each byte against the queue.
    initial begin
        forever begin
            @(negedge HCLK);
            if (bus.UART_TX === 1'b0) begin
                repeat (2) @(negedge HCLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge HCLK);
                    rx_b[i] = bus.UART_TX;
                end
                repeat (CPB) @(negedge HCLK);
                rx_stop = bus.UART_TX;
                rx_count++;
                if (!discard) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL rx_unexpected: got byte %02h, expected no byte", rx_b);
                    end else begin
                        rx_e = exp_q.pop_front();
                        check($sformatf("rx_byte%0d", rx_count), rx_b, rx_e);
                        check("rx_stop", rx_stop, 1'b1);
                    end
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, busy_n, first_low, base, c;
        bit seen, busy_seen;

        HRESET        = 1'b1;
        bus.ERRCOUNT  = 32'h0;
        bus.CHKCOUNT  = 8'h00;
        bus.S_WRITE   = 1'b0;
        bus.S_CHECK   = 1'b0;
        bus.S_SUCCESS = 1'b0;
        bus.S_FAILED  = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        check("reset_tx", bus.UART_TX, 1'b1);
        check("reset_busy", bus.BUSY, 1'b0);

        busy_seen = 1'b0;
        repeat (200) begin
            @(negedge HCLK);
            if (bus.BUSY || !bus.UART_TX) busy_seen = 1'b1;
        end
        check("idle_activity", busy_seen, 1'b0);
        check("idle_rx_count", rx_count, 0);

        // Write phase starts: first line, with latency and busy-length checks.
        push_str("W 00 00000000\r\n");
        bus.S_WRITE = 1'b1;
        cyc = 0; busy_n = 0; first_low = -1; seen = 1'b0;
        while (cyc < 2000) begin
            @(posedge HCLK);
            #1;
            cyc++;
            if (bus.BUSY) begin
                busy_n++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            if (first_low < 0 && bus.UART_TX === 1'b0) first_low = cyc;
        end
        check("start_latency_le4", (first_low >= 1 && first_low <= 4), 1'b1);
        check("busy_len_in_range", (busy_n >= 600 && busy_n <= 660), 1'b1);
        wait_done("line_w_done", 400);

        // Check phase with write still set: C wins, then coalesced CHKCOUNT changes.
        @(negedge HCLK);
        push_str("C 3A 0000BEEF\r\n");
        bus.S_CHECK  = 1'b1;
        bus.CHKCOUNT = 8'h3A;
        bus.ERRCOUNT = 32'h0000BEEF;
        repeat (50) @(negedge HCLK);
        check("busy_mid_line", bus.BUSY, 1'b1);
        push_str("C 03 0000BEEF\r\n");
        bus.CHKCOUNT = 8'h01;
        repeat (50) @(negedge HCLK);
        bus.CHKCOUNT = 8'h02;
        repeat (50) @(negedge HCLK);
        bus.CHKCOUNT = 8'h03;
        wait_done("line_c_pair_done", 4000);
        busy_seen = 1'b0;
        repeat (200) begin
            @(negedge HCLK);
            if (bus.BUSY) busy_seen = 1'b1;
        end
        check("no_third_line", busy_seen, 1'b0);

        // Failed and success together: F has priority.
        push_str("F 00 FFFFFFFF\r\n");
        bus.S_FAILED  = 1'b1;
        bus.S_SUCCESS = 1'b1;
        bus.CHKCOUNT  = 8'h00;
        bus.ERRCOUNT  = 32'hFFFFFFFF;
        wait_done("line_f_done", 2000);

        // Reset during byte 5 of a line.
        repeat (10) @(negedge HCLK);
        discard = 1'b1;
        base = rx_count;
        bus.S_FAILED = 1'b0;
        c = 0;
        while (rx_count < base + 5 && c < 2000) begin
            @(negedge HCLK);
            c++;
        end
        while (bus.UART_TX !== 1'b0 && c < 2000) begin
            @(negedge HCLK);
            c++;
        end
        check("reach_byte5", (c < 2000), 1'b1);
        repeat (8) @(negedge HCLK);
        HRESET        = 1'b1;
        bus.S_WRITE   = 1'b0;
        bus.S_CHECK   = 1'b0;
        bus.S_SUCCESS = 1'b0;
        bus.S_FAILED  = 1'b0;
        bus.CHKCOUNT  = 8'h00;
        bus.ERRCOUNT  = 32'h0;
        @(posedge HCLK);
        #1;
        check("rst_mid_tx_high", bus.UART_TX, 1'b1);
        check("rst_mid_busy_low", bus.BUSY, 1'b0);
        @(negedge HCLK);
        HRESET = 1'b0;
        busy_seen = 1'b0;
        repeat (150) begin
            @(negedge HCLK);
            if (bus.BUSY) busy_seen = 1'b1;
        end
        discard = 1'b0;
        base = rx_count;
        repeat (100) begin
            @(negedge HCLK);
            if (bus.BUSY || !bus.UART_TX) busy_seen = 1'b1;
        end
        check("no_resumed_line", busy_seen, 1'b0);
        check("no_resumed_bytes", rx_count, base);

        // Next trigger after reset sends a complete line.
        push_str("W 5C 12345678\r\n");
        bus.S_WRITE  = 1'b1;
        bus.CHKCOUNT = 8'h5C;
        bus.ERRCOUNT = 32'h12345678;
        wait_done("line_after_rst_done", 2000);

        repeat (20) @(negedge HCLK);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
